// File: rtl/render_controller_pkg.sv
// Shared widths, view record and FSM encoding for the render controller slice.
package render_controller_pkg;
  localparam int COORD_W = 27;
  localparam int TIME_W  = 32;
  localparam int FRAME_W = 16;
  localparam int ID_W    = 6;
  localparam int ADDR_W  = 19;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t min_x;
    coord_t min_y;
    coord_t dx;
    coord_t dy;
  } view_t;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    RESET_SOLVERS = 2'd1,
    SOLVING       = 2'd2,
    DONE          = 2'd3
  } state_t;
endpackage

// File: rtl/render_controller_if.sv
// View-update request channel: the host drives a new view, the controller accepts it.
interface render_controller_if;
  import render_controller_pkg::*;
  logic   req_valid;
  logic   req_ready;
  coord_t req_min_x;
  coord_t req_min_y;
  coord_t req_dx;
  coord_t req_dy;

  modport master (output req_valid, req_min_x, req_min_y, req_dx, req_dy,
                  input  req_ready);
  modport slave  (input  req_valid, req_min_x, req_min_y, req_dx, req_dy,
                  output req_ready);
endinterface

// File: rtl/render_controller_scan_addr_gen.sv
// Display scan address generator: walks pixels in raster order and maps each to
// (lane, address) by interleaving across lanes, using counters only.
module scan_addr_gen
  import render_controller_pkg::*;
#(
  parameter int NUM_SOLVERS = 1,
  parameter int NUM_COLUMNS = 640,
  parameter int NUM_ROWS    = 480
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scan_start,
  input  logic              scan_advance,
  output logic [ID_W-1:0]   rd_solver_id,
  output logic [ADDR_W-1:0] rd_addr
);
  localparam int TOTAL = NUM_COLUMNS * NUM_ROWS;
  localparam int PIX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Next pixel: start restarts the frame and beats a simultaneous advance;
  // the lane id rolls over into the address, the last pixel wraps to zero.
  always_comb begin
    pix_d  = pix_q;
    id_d   = id_q;
    addr_d = addr_q;
    if (scan_start) begin
      pix_d  = '0;
      id_d   = '0;
      addr_d = '0;
    end else if (scan_advance) begin
      if (pix_q == PIX_W'(TOTAL - 1)) begin
        pix_d  = '0;
        id_d   = '0;
        addr_d = '0;
      end else begin
        pix_d = pix_q + 1'b1;
        if (id_q == ID_W'(NUM_SOLVERS - 1)) begin
          id_d   = '0;
          addr_d = addr_q + 1'b1;
        end else begin
          id_d = id_q + 1'b1;
        end
      end
    end
  end

  // Scan counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_q  <= '0;
      id_q   <= '0;
      addr_q <= '0;
    end else begin
      pix_q  <= pix_d;
      id_q   <= id_d;
      addr_q <= addr_d;
    end
  end

  assign rd_solver_id = id_q;
  assign rd_addr      = addr_q;
endmodule

// File: rtl/render_controller.sv
// Render controller: latches view requests, sequences solver reset / solve,
// records frame statistics and generates the display read address.
module render_controller
  import render_controller_pkg::*;
#(
  parameter int NUM_SOLVERS  = 1,   // 1..64 lanes
  parameter int NUM_COLUMNS  = 640,
  parameter int NUM_ROWS     = 480,
  parameter int RESET_CYCLES = 2    // >= 1
) (
  input  logic               clock,
  input  logic               reset,
  render_controller_if.slave req,
  output coord_t             min_x,
  output coord_t             min_y,
  output coord_t             dx,
  output coord_t             dy,
  output logic               solver_reset,
  input  logic               solver_done,
  input  logic [TIME_W-1:0]  solve_time,
  output logic               frame_ready,
  output logic [TIME_W-1:0]  last_solve_time,
  output logic [FRAME_W-1:0] frame_count,
  input  logic               scan_start,
  input  logic               scan_advance,
  output logic [ID_W-1:0]    rd_solver_id,
  output logic [ADDR_W-1:0]  rd_addr
);
  localparam int RCNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic               first_q, first_d;
  view_t              view_q, view_d;
  logic [TIME_W-1:0]  last_q, last_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic               ready_q, ready_d;
  logic               sreset_q, sreset_d;
  logic               fready_q, fready_d;
  logic               accept;

  // Next-state: an accepted request always restarts the solver sequence
  // (aborting any solve in flight); done is masked on the first solve cycle
  // because the solver array may still show the previous frame's flag.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    first_d = 1'b0;
    view_d  = view_q;
    last_d  = last_q;
    fcnt_d  = fcnt_q;
    accept  = req.req_valid && ready_q;
    if (accept) begin
      state_d = RESET_SOLVERS;
      rcnt_d  = '0;
      view_d  = '{min_x: req.req_min_x, min_y: req.req_min_y,
                  dx: req.req_dx, dy: req.req_dy};
    end else begin
      case (state_q)
        RESET_SOLVERS: begin
          if (rcnt_q == RCNT_W'(RESET_CYCLES - 1)) begin
            state_d = SOLVING;
            first_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        SOLVING: begin
          if (solver_done && !first_q) begin
            state_d = DONE;
            last_d  = solve_time;
            fcnt_d  = fcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    ready_d  = (state_d != RESET_SOLVERS);
    sreset_d = (state_d == IDLE) || (state_d == RESET_SOLVERS);
    fready_d = (state_d == DONE);
  end

  // FSM, view, statistics and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rcnt_q   <= '0;
      first_q  <= 1'b0;
      view_q   <= '0;
      last_q   <= '0;
      fcnt_q   <= '0;
      ready_q  <= 1'b1;
      sreset_q <= 1'b1;
      fready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      first_q  <= first_d;
      view_q   <= view_d;
      last_q   <= last_d;
      fcnt_q   <= fcnt_d;
      ready_q  <= ready_d;
      sreset_q <= sreset_d;
      fready_q <= fready_d;
    end
  end

  assign req.req_ready     = ready_q;
  assign solver_reset      = sreset_q;
  assign frame_ready       = fready_q;
  assign last_solve_time   = last_q;
  assign frame_count       = fcnt_q;
  assign min_x             = view_q.min_x;
  assign min_y             = view_q.min_y;
  assign dx                = view_q.dx;
  assign dy                = view_q.dy;

  scan_addr_gen #(
    .NUM_SOLVERS (NUM_SOLVERS),
    .NUM_COLUMNS (NUM_COLUMNS),
    .NUM_ROWS    (NUM_ROWS)
  ) u_scan (
    .clock        (clock),
    .reset        (reset),
    .scan_start   (scan_start),
    .scan_advance (scan_advance),
    .rd_solver_id (rd_solver_id),
    .rd_addr      (rd_addr)
  );
endmodule

// File: tb/tb_render_controller.sv
// Bench for render_controller: directed scenarios plus a randomized run, all
// checked against a cycles-since-request / pixel-index reference model.
module tb_render_controller;
  import render_controller_pkg::*;

  localparam int RC    = 2;
  localparam int NS    = 3;
  localparam int NC    = 4;
  localparam int NR    = 2;
  localparam int TOTAL = NC * NR;

  logic               clock = 1'b0;
  logic               reset;
  logic               solver_done;
  logic [TIME_W-1:0]  solve_time;
  logic               scan_start, scan_advance;
  coord_t             min_x, min_y, dx, dy;
  logic               solver_reset, frame_ready;
  logic [TIME_W-1:0]  last_solve_time;
  logic [FRAME_W-1:0] frame_count;
  logic [ID_W-1:0]    rd_solver_id;
  logic [ADDR_W-1:0]  rd_addr;

  render_controller_if req_if();

  render_controller #(
    .NUM_SOLVERS(NS), .NUM_COLUMNS(NC), .NUM_ROWS(NR), .RESET_CYCLES(RC)
  ) dut (
    .clock(clock), .reset(reset), .req(req_if),
    .min_x(min_x), .min_y(min_y), .dx(dx), .dy(dy),
    .solver_reset(solver_reset), .solver_done(solver_done), .solve_time(solve_time),
    .frame_ready(frame_ready), .last_solve_time(last_solve_time),
    .frame_count(frame_count), .scan_start(scan_start), .scan_advance(scan_advance),
    .rd_solver_id(rd_solver_id), .rd_addr(rd_addr)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: progress is "cycles since the last accepted request".
  bit                 m_started, m_finished;
  int                 m_age;
  logic [4*COORD_W-1:0] m_view;
  logic [FRAME_W-1:0] m_fc;
  logic [TIME_W-1:0]  m_last;
  int                 m_pix;

  function automatic bit exp_ready();
    return !(m_started && !m_finished && m_age < RC);
  endfunction
  function automatic bit exp_sreset();
    return !m_started || (!m_finished && m_age < RC);
  endfunction

  // One clock edge; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    bit acc;
    @(posedge clock);
    acc = req_if.req_valid && exp_ready();
    if (reset) begin
      m_started = 0; m_finished = 0; m_age = 0; m_view = '0;
      m_fc = '0; m_last = '0; m_pix = 0;
    end else begin
      if (acc) begin
        m_started = 1; m_finished = 0; m_age = 0;
        m_view = {req_if.req_min_x, req_if.req_min_y, req_if.req_dx, req_if.req_dy};
      end else if (m_started && !m_finished) begin
        if (m_age > RC && solver_done) begin
          m_finished = 1; m_fc = m_fc + 1'b1; m_last = solve_time;
        end
        m_age++;
      end
      if (scan_start) m_pix = 0;
      else if (scan_advance) m_pix = (m_pix + 1) % TOTAL;
    end
    #1;
  endtask

  task automatic send_req(input coord_t x, input coord_t y, input coord_t ddx, input coord_t ddy);
    req_if.req_valid = 1; req_if.req_min_x = x; req_if.req_min_y = y;
    req_if.req_dx = ddx; req_if.req_dy = ddy;
    tick();
    req_if.req_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    n_cmp++; if (req_if.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_if.req_ready); end
    n_cmp++; if (solver_reset !== 1'b1) begin n_bad++; $display("FAIL reset_sreset: got %b want 1", solver_reset); end
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL reset_fready: got %b want 0", frame_ready); end
    n_cmp++; if ({frame_count, last_solve_time} !== '0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", frame_count, last_solve_time); end
    n_cmp++; if ({min_x, min_y, dx, dy} !== '0) begin n_bad++; $display("FAIL reset_view: got %0d %0d %0d %0d want 0", min_x, min_y, dx, dy); end
    n_cmp++; if ({rd_solver_id, rd_addr} !== '0) begin n_bad++; $display("FAIL reset_scan: got %0d/%0d want 0/0", rd_solver_id, rd_addr); end
    reset = 0;
    tick();
  endtask

  // -2.0 and -1.5 in Q3.24.
  task automatic test_request();
    coord_t mx, my;
    mx = -27'sd33554432; my = -27'sd25165824;
    send_req(mx, my, 27'sd3, 27'sd3);
    for (int i = 0; i < RC; i++) begin
      n_cmp++; if (req_if.req_ready !== 1'b0) begin n_bad++; $display("FAIL req_busy_ready[%0d]: got %b want 0", i, req_if.req_ready); end
      n_cmp++; if (solver_reset !== 1'b1) begin n_bad++; $display("FAIL req_sreset[%0d]: got %b want 1", i, solver_reset); end
      tick();
    end
    n_cmp++; if (req_if.req_ready !== 1'b1 || solver_reset !== 1'b0) begin n_bad++; $display("FAIL req_solving: got ready=%b sreset=%b want 1/0", req_if.req_ready, solver_reset); end
    n_cmp++; if (min_x !== mx || min_y !== my || dx !== 27'sd3 || dy !== 27'sd3) begin n_bad++; $display("FAIL req_view: got %0d %0d %0d %0d want %0d %0d 3 3", min_x, min_y, dx, dy, mx, my); end
  endtask

  task automatic test_solve_done();
    for (int i = 0; i < 200 && m_age < RC + 100; i++) tick();
    solver_done = 1; solve_time = 100;
    tick();
    solver_done = 0; solve_time = $urandom;
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL done_fready: got %b want 1", frame_ready); end
    n_cmp++; if (last_solve_time !== 32'd100) begin n_bad++; $display("FAIL done_time: got %0d want 100", last_solve_time); end
    n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL done_count: got %0d want 1", frame_count); end
    tick(); tick();
    n_cmp++; if (frame_ready !== 1'b1 || solver_reset !== 1'b0) begin n_bad++; $display("FAIL done_hold: got fready=%b sreset=%b want 1/0", frame_ready, solver_reset); end
  endtask

  task automatic test_abort();
    coord_t a, b;
    send_req(27'($urandom), 27'($urandom), 27'($urandom), 27'($urandom));
    for (int i = 0; i < 200 && m_age < RC + 50; i++) tick();
    a = 27'($urandom); b = 27'($urandom);
    send_req(a, b, b, a);
    n_cmp++; if (req_if.req_ready !== 1'b0 || solver_reset !== 1'b1) begin n_bad++; $display("FAIL abort_state: got ready=%b sreset=%b want 0/1", req_if.req_ready, solver_reset); end
    n_cmp++; if (frame_count !== 16'd1 || last_solve_time !== 32'd100) begin n_bad++; $display("FAIL abort_stats: got %0d/%0d want 1/100", frame_count, last_solve_time); end
    n_cmp++; if (min_x !== a || min_y !== b || dx !== b || dy !== a) begin n_bad++; $display("FAIL abort_view: got %0d %0d %0d %0d want %0d %0d %0d %0d", min_x, min_y, dx, dy, a, b, b, a); end
  endtask

  task automatic test_first_cycle();
    for (int i = 0; i < 20 && m_age < RC; i++) tick();
    solver_done = 1;
    tick();
    solver_done = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (frame_ready !== 1'b0 || req_if.req_ready !== 1'b1 || solver_reset !== 1'b0) begin n_bad++; $display("FAIL first_ignore[%0d]: got fready=%b ready=%b sreset=%b want 0/1/0", i, frame_ready, req_if.req_ready, solver_reset); end
      tick();
    end
  endtask

  task automatic test_scan_seq();
    int ids[9], adr[9];
    ids = '{0, 1, 2, 0, 1, 2, 0, 1, 0};
    adr = '{0, 0, 0, 1, 1, 1, 2, 2, 0};
    scan_start = 1; tick(); scan_start = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin scan_advance = 1; tick(); scan_advance = 0; end
      n_cmp++; if (rd_solver_id !== ID_W'(ids[i]) || rd_addr !== ADDR_W'(adr[i])) begin n_bad++; $display("FAIL scan_seq[%0d]: got %0d/%0d want %0d/%0d", i, rd_solver_id, rd_addr, ids[i], adr[i]); end
    end
  endtask

  task automatic test_scan_collision();
    scan_advance = 1; tick(); tick(); tick(); tick();
    scan_start = 1; tick();
    scan_start = 0; scan_advance = 0;
    n_cmp++; if (rd_solver_id !== '0 || rd_addr !== '0) begin n_bad++; $display("FAIL scan_collide: got %0d/%0d want 0/0", rd_solver_id, rd_addr); end
  endtask

  task automatic test_reset_mid();
    send_req(27'sd5, 27'sd6, 27'sd7, 27'sd8);
    for (int i = 0; i < RC + 3; i++) tick();
    scan_advance = 1; tick(); tick();
    reset = 1; req_if.req_valid = 1; solver_done = 1; scan_start = 0;
    tick();
    reset = 0; req_if.req_valid = 0; solver_done = 0; scan_advance = 0;
    n_cmp++; if (req_if.req_ready !== 1'b1 || solver_reset !== 1'b1 || frame_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_ctl: got ready=%b sreset=%b fready=%b want 1/1/0", req_if.req_ready, solver_reset, frame_ready); end
    n_cmp++; if ({min_x, min_y, dx, dy} !== '0 || frame_count !== '0 || last_solve_time !== '0) begin n_bad++; $display("FAIL midreset_regs: got x=%0d fc=%0d t=%0d want 0", min_x, frame_count, last_solve_time); end
    n_cmp++; if (rd_solver_id !== '0 || rd_addr !== '0) begin n_bad++; $display("FAIL midreset_scan: got %0d/%0d want 0/0", rd_solver_id, rd_addr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom % 300) == 0;
      req_if.req_valid = ($urandom % 40) == 0;
      req_if.req_min_x = 27'($urandom); req_if.req_min_y = 27'($urandom);
      req_if.req_dx    = 27'($urandom); req_if.req_dy    = 27'($urandom);
      solver_done      = ($urandom % 12) == 0;
      solve_time       = $urandom;
      scan_start       = ($urandom % 25) == 0;
      scan_advance     = $urandom % 2;
      tick();
      n_cmp++; if (req_if.req_ready !== exp_ready() || solver_reset !== exp_sreset() || frame_ready !== m_finished) begin n_bad++; $display("FAIL rnd_ctl @%0d: got ready=%b sreset=%b fready=%b want %b/%b/%b", i, req_if.req_ready, solver_reset, frame_ready, exp_ready(), exp_sreset(), m_finished); end
      n_cmp++; if ({min_x, min_y, dx, dy} !== m_view) begin n_bad++; $display("FAIL rnd_view @%0d: got %h want %h", i, {min_x, min_y, dx, dy}, m_view); end
      n_cmp++; if (frame_count !== m_fc || last_solve_time !== m_last) begin n_bad++; $display("FAIL rnd_stats @%0d: got %0d/%0d want %0d/%0d", i, frame_count, last_solve_time, m_fc, m_last); end
      n_cmp++; if (rd_solver_id !== ID_W'(m_pix % NS) || rd_addr !== ADDR_W'(m_pix / NS)) begin n_bad++; $display("FAIL rnd_scan @%0d: got %0d/%0d want %0d/%0d", i, rd_solver_id, rd_addr, m_pix % NS, m_pix / NS); end
    end
    reset = 0; req_if.req_valid = 0; solver_done = 0; scan_start = 0; scan_advance = 0;
  endtask

  initial begin
    reset = 1; solver_done = 0; solve_time = '0; scan_start = 0; scan_advance = 0;
    req_if.req_valid = 0; req_if.req_min_x = '0; req_if.req_min_y = '0;
    req_if.req_dx = '0; req_if.req_dy = '0;
    m_started = 0; m_finished = 0; m_age = 0; m_view = '0; m_fc = '0; m_last = '0; m_pix = 0;
    test_reset();
    test_request();
    test_solve_done();
    test_abort();
    test_first_cycle();
    test_scan_seq();
    test_scan_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/render_controller.md
RENDER_CONTROLLER -- requirements
Module: render_controller

Interface
REQ-001 Parameter NUM_SOLVERS, default 1: number of solver lanes; legal range 1..64.
REQ-002 Parameter NUM_COLUMNS, default 640: pixels per row.
REQ-003 Parameter NUM_ROWS, default 480: rows per frame.
REQ-004 Parameter RESET_CYCLES, default 2: solver_reset pulse length in cycles; minimum 1.
REQ-005 clock  in  1  system clock; all logic is on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid / req_ready  in / out  1 / 1  view-update handshake.
REQ-008 req_min_x, req_min_y, req_dx, req_dy  in  27 each, signed  requested view.
REQ-009 min_x, min_y, dx, dy  out  27 each, signed  registered view driven to the solver array.
REQ-010 solver_reset  out  1  synchronous reset to the solver array.
REQ-011 solver_done  in  1  all-lanes-done flag from the solver array.
REQ-012 solve_time  in  32  cycle counter from the solver array.
REQ-013 frame_ready  out  1  current frame fully solved.
REQ-014 last_solve_time  out  32  solve_time captured at the last completion.
REQ-015 frame_count  out  16  completed-frame counter.
REQ-016 scan_start, scan_advance  in  1 / 1  display frame-start pulse / next-pixel pulse.
REQ-017 rd_solver_id  out  6, and rd_addr  out  19  read port address to the solver RAMs.

Function
REQ-018 FSM states: IDLE, RESET_SOLVERS, SOLVING, DONE.
REQ-019 req_ready SHALL be 1 in IDLE, SOLVING and DONE, and 0 in RESET_SOLVERS.
REQ-020 A request is accepted on any cycle where req_valid and req_ready are both 1. Acceptance loads all four view outputs from the request inputs, clears the reset counter, and enters RESET_SOLVERS.
REQ-021 Acceptance in SOLVING aborts the running solve. frame_count and last_solve_time are left unchanged.
REQ-022 solver_reset SHALL be 1 in IDLE and RESET_SOLVERS, and 0 in SOLVING and DONE.
REQ-023 RESET_SOLVERS lasts exactly RESET_CYCLES cycles, then the FSM enters SOLVING.
REQ-024 solver_done is ignored during the first SOLVING cycle.
REQ-025 On a later SOLVING cycle with solver_done=1, the FSM enters DONE, captures last_solve_time from solve_time, and increments frame_count.
REQ-026 frame_count increments modulo 2^16.
REQ-027 frame_ready SHALL be 1 only in DONE.
REQ-028 The view outputs SHALL remain stable except on request acceptance.
REQ-029 Pixel mapping: pixel p = row*NUM_COLUMNS + col belongs to lane p mod NUM_SOLVERS, at address p div NUM_SOLVERS.
REQ-030 The mapping SHALL be implemented with counters only; no divider or multiplier is allowed.
REQ-031 scan_start sets rd_solver_id=0, rd_addr=0 and the pixel counter to 0 on the next edge.
REQ-032 scan_advance steps the pixel: rd_solver_id increments. When it would reach NUM_SOLVERS it wraps to 0 and rd_addr increments.
REQ-033 When scan_advance is applied on pixel NUM_COLUMNS*NUM_ROWS-1, the scan wraps to pixel 0 (id 0, addr 0).
REQ-034 If scan_start and scan_advance occur in the same cycle, scan_start wins.
REQ-035 The scan logic is independent of the FSM state.

Reset
REQ-036 Reset state: IDLE; view outputs 0; solver_reset 1; frame_ready 0; last_solve_time 0; frame_count 0; rd_solver_id 0; rd_addr 0; pixel counter 0; reset counter 0.
REQ-037 Reset asserted mid-solve or mid-scan overrides all other inputs on that edge.

Structure
REQ-038 A shared package holds the view coordinate width (27), the FSM state encoding, and the time width (32).
REQ-039 A single sub-module, scan_addr_gen, holds the REQ-029..REQ-034 counters.
REQ-040 The FSM, the view registers and the statistics registers reside in render_controller.

Verification
REQ-041 Reset, then request min_x=-2.0 (Q-format), dx=3 -> req_ready=0 for 2 cycles; solver_reset=1 for exactly 2 cycles; view outputs hold the request values.
REQ-042 Raise solver_done 100 cycles into SOLVING with solve_time=100 -> frame_ready=1 next cycle, last_solve_time=100, frame_count=1.
REQ-043 New request 50 cycles into SOLVING -> RESET_SOLVERS re-entered, frame_count unchanged, new view latched.
REQ-044 NUM_SOLVERS=3, NUM_COLUMNS=4, NUM_ROWS=2: scan_start then 8 advances -> (id,addr) sequence 0/0, 1/0, 2/0, 0/1, 1/1, 2/1, 0/2, 1/2, then 0/0.
REQ-045 scan_start with scan_advance in the same cycle, mid-frame -> id 0, addr 0.
REQ-046 solver_done=1 held during the first SOLVING cycle only -> FSM stays in SOLVING.
